cache_refill_unit: RTL and testbench
====================================

CACHE_REFILL_UNIT -- requirements
Module: cache_refill_unit

Interface
REQ-001: The block SHALL have no parameters; geometry is fixed at a 12-bit byte address, 16-byte lines, 8 sets x 2 ways, tag = addr[11:7], set = addr[6:4], offset = addr[3:0].
REQ-002: clk  input  1  single clock; all state updates on its rising edge.
REQ-003: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004: miss_req  input  1  the cache signals a miss for miss_addr; sampled only in IDLE.
REQ-005: miss_addr  input  12  byte address of the missing access.
REQ-006: hit_valid  input  1  the cache reports a hit this cycle, for LRU update.
REQ-007: hit_set  input  3  set index of the reported hit.
REQ-008: hit_way  input  1  way of the reported hit.
REQ-009: mem_rd  output  1  byte read strobe to main memory.
REQ-010: mem_addr  output  12  byte address of the current memory read.
REQ-011: mem_data  input  8  read data, valid exactly one cycle after the cycle in which mem_rd is high.
REQ-012: busy  output  1  a refill is in progress; new misses are not accepted.
REQ-013: fill_valid  output  1  one-cycle pulse; fill_line, fill_tag, fill_set and fill_way are valid.
REQ-014: fill_line  output  128  assembled line; byte at offset k on bits [8k+7:8k].
REQ-015: fill_tag  output  5  tag of the refilled line.
REQ-016: fill_set  output  3  set of the refilled line.
REQ-017: fill_way  output  1  victim way to overwrite.

Function
REQ-018: The FSM SHALL have the states IDLE, FETCH, DRAIN and DONE, with the transitions IDLE->FETCH, FETCH->DRAIN, DRAIN->DONE and DONE->IDLE.
REQ-019: In IDLE with miss_req=1, the block SHALL latch miss_addr[11:4], latch victim fill_way = ~lru[miss_addr[6:4]], clear the line register to 0, clear the beat counter, and enter FETCH.
REQ-020: In FETCH, mem_rd SHALL be 1 and mem_addr SHALL be {line_addr, beat}, for beat 0..15 on 16 consecutive cycles; the counter SHALL wrap 15->0 as the FSM enters DRAIN.
REQ-021: The mem_data byte returned for beat k SHALL be written to line bits [8k+7:8k] on the edge that ends the cycle after beat k's read; DRAIN SHALL capture beat 15 with mem_rd=0.
REQ-022: In DONE, fill_valid SHALL be 1 for exactly one cycle, with the line, tag, set and way held stable; the next state SHALL be IDLE.
REQ-023: Latency: with acceptance on edge E, fill_valid SHALL be high in cycle 18 after E (16 FETCH cycles, 1 DRAIN cycle, then DONE).
REQ-024: busy SHALL be 1 in FETCH, DRAIN and DONE, and 0 in IDLE; miss_req while busy SHALL be ignored, with no queueing.
REQ-025: fill_line, fill_tag, fill_set and fill_way SHALL hold their last values outside DONE; mem_addr SHALL be 0 when mem_rd=0.
REQ-026: LRU: lru[7:0] holds one bit per set, equal to the most-recently-used way; hit_valid SHALL set lru[hit_set] <= hit_way in any state.
REQ-027: In DONE, lru[fill_set] SHALL be set to fill_way; if hit_valid is high for the same set in that cycle, the fill update SHALL win.
REQ-028: A hit that updates lru during FETCH or DRAIN SHALL NOT change the already-latched fill_way.

Reset
REQ-029: With rst=1 at an edge, the FSM SHALL go to IDLE from any state (mid-refill included) and the partial line SHALL be discarded.
REQ-030: With rst=1 at an edge, busy, mem_rd and fill_valid SHALL be 0, mem_addr, fill_line, fill_tag, fill_set and fill_way SHALL be 0, lru SHALL be 8'h00, and the beat counter SHALL be 0.
REQ-031: rst SHALL take priority over miss_req and hit_valid in the same cycle.

Verification
REQ-032: Memory model mem_data = addr[7:0] ^ 8'hA5, one-cycle latency; miss_addr=12'hFF0 after reset -> mem_addr 12'hFF0..12'hFFF, fill_tag=5'h1F, fill_set=3'h7, fill_way=1, fill_line byte k = (8'hF0+k)^8'hA5, fill_valid in cycle 18.
REQ-033: Back-to-back misses at 12'hFF0 then 12'h01F (set 1) -> the second fill_way=1; a repeated miss on set 7 gives fill_way=0.
REQ-034: miss_req held high throughout a refill -> exactly one fill_valid pulse, then re-acceptance in the first IDLE cycle.
REQ-035: hit_valid with set 3 and way 0 during FETCH, then a miss on set 3 -> fill_way=1; hit and fill on the same set in the DONE cycle -> lru equals fill_way.
REQ-036: rst asserted at beat 7 of a refill -> next cycle busy=0, mem_rd=0, no fill_valid pulse, and the next miss starts at beat 0.

Source files
------------

// File: rtl/cache_refill_unit.sv
// Cache line refill engine: fetches a 16-byte line byte by byte,
// picks the victim way from a per-set LRU bit and presents the fill.
module cache_refill_unit (
    input  logic         clk,
    input  logic         rst,
    input  logic         miss_req,
    input  logic [11:0]  miss_addr,
    input  logic         hit_valid,
    input  logic [2:0]   hit_set,
    input  logic         hit_way,
    output logic         mem_rd,
    output logic [11:0]  mem_addr,
    input  logic [7:0]   mem_data,
    output logic         busy,
    output logic         fill_valid,
    output logic [127:0] fill_line,
    output logic [4:0]   fill_tag,
    output logic [2:0]   fill_set,
    output logic         fill_way
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [3:0]   beat_q, beat_d;
    logic [7:0]   line_addr_q, line_addr_d;
    logic [127:0] line_q, line_d;
    logic         victim_q, victim_d;
    logic [7:0]   lru_q, lru_d;
    logic [127:0] fill_line_q, fill_line_d;
    logic [4:0]   fill_tag_q, fill_tag_d;
    logic [2:0]   fill_set_q, fill_set_d;
    logic         fill_way_q, fill_way_d;
    logic [3:0]   prev_beat;

    // Read data lags the strobe by one cycle, so capture the previous beat.
    assign prev_beat  = beat_q - 4'd1;

    assign mem_rd     = (state_q == FETCH);
    assign mem_addr   = mem_rd ? {line_addr_q, beat_q} : 12'h000;
    assign busy       = (state_q != IDLE);
    assign fill_valid = (state_q == DONE);
    assign fill_line  = fill_line_q;
    assign fill_tag   = fill_tag_q;
    assign fill_set   = fill_set_q;
    assign fill_way   = fill_way_q;

    // Next-state logic for the refill FSM, line assembly and LRU bits.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        line_addr_d = line_addr_q;
        line_d      = line_q;
        victim_d    = victim_q;
        lru_d       = lru_q;
        fill_line_d = fill_line_q;
        fill_tag_d  = fill_tag_q;
        fill_set_d  = fill_set_q;
        fill_way_d  = fill_way_q;

        if (hit_valid) begin
            lru_d[hit_set] = hit_way;
        end

        unique case (state_q)
            IDLE: begin
                if (miss_req) begin
                    line_addr_d = miss_addr[11:4];
                    victim_d    = ~lru_q[miss_addr[6:4]];
                    line_d      = '0;
                    beat_d      = 4'd0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (beat_q != 4'd0) begin
                    line_d[{prev_beat, 3'b000} +: 8] = mem_data;
                end
                beat_d = beat_q + 4'd1;
                if (beat_q == 4'd15) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                line_d[127:120] = mem_data;
                fill_line_d     = line_d;
                fill_tag_d      = line_addr_q[7:3];
                fill_set_d      = line_addr_q[2:0];
                fill_way_d      = victim_q;
                state_d         = DONE;
            end
            DONE: begin
                // The fill overrides a same-cycle hit on the same set.
                lru_d[fill_set_q] = fill_way_q;
                state_d           = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= 4'd0;
            line_addr_q <= 8'd0;
            line_q      <= '0;
            victim_q    <= 1'b0;
            lru_q       <= 8'h00;
            fill_line_q <= '0;
            fill_tag_q  <= 5'd0;
            fill_set_q  <= 3'd0;
            fill_way_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            line_addr_q <= line_addr_d;
            line_q      <= line_d;
            victim_q    <= victim_d;
            lru_q       <= lru_d;
            fill_line_q <= fill_line_d;
            fill_tag_q  <= fill_tag_d;
            fill_set_q  <= fill_set_d;
            fill_way_q  <= fill_way_d;
        end
    end

endmodule

// File: tb/tb_cache_refill_unit.sv
// Directed bench for cache_refill_unit with a one-cycle-latency
// memory model returning addr[7:0] ^ 8'hA5.
module tb_cache_refill_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_req;
    logic [11:0]  miss_addr;
    logic         hit_valid;
    logic [2:0]   hit_set;
    logic         hit_way;
    logic         mem_rd;
    logic [11:0]  mem_addr;
    logic [7:0]   mem_data;
    logic         busy;
    logic         fill_valid;
    logic [127:0] fill_line;
    logic [4:0]   fill_tag;
    logic [2:0]   fill_set;
    logic         fill_way;

    int checks = 0;
    int errors = 0;

    cache_refill_unit dut (
        .clk        (clk),
        .rst        (rst),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .hit_valid  (hit_valid),
        .hit_set    (hit_set),
        .hit_way    (hit_way),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .busy       (busy),
        .fill_valid (fill_valid),
        .fill_line  (fill_line),
        .fill_tag   (fill_tag),
        .fill_set   (fill_set),
        .fill_way   (fill_way)
    );

    always #5 clk = ~clk;

    // Memory: data for a read strobed in one cycle appears in the next.
    always @(posedge clk) begin
        mem_data <= mem_rd ? (mem_addr[7:0] ^ 8'hA5) : 8'h00;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_line(input logic [11:0] a);
        logic [127:0] l;
        logic [7:0]   b;
        l = '0;
        for (int k = 0; k < 16; k++) begin
            b = {a[7:4], 4'(k)};
            l[8*k +: 8] = b ^ 8'hA5;
        end
        return l;
    endfunction

    // Accept a miss, optionally check every fetch address, optionally
    // inject a hit in cycle hc after acceptance, and check latency 18.
    task automatic refill(input logic [11:0] a, input bit chk_addr,
                          input int hc, input logic [2:0] hs,
                          input logic hw);
        int n;
        miss_req  = 1'b1;
        miss_addr = a;
        step();
        miss_req = 1'b0;
        n = 1;
        while (n < 40) begin
            hit_valid = (n == hc);
            hit_set   = hs;
            hit_way   = hw;
            if (chk_addr && n <= 16) begin
                chk("fetch_rd", 128'(mem_rd), 128'(1'b1));
                chk("fetch_addr", 128'(mem_addr),
                    128'({a[11:4], 4'(n - 1)}));
            end
            if (fill_valid) break;
            step();
            n++;
        end
        chk("fill_latency", 128'(n), 128'(18));
        step();
        hit_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        rst       = 1'b1;
        miss_req  = 1'b1;
        miss_addr = 12'hFF0;
        hit_valid = 1'b1;
        hit_set   = 3'd7;
        hit_way   = 1'b1;
        step();
        step();
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_mem_rd", 128'(mem_rd), 128'(1'b0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(12'h000));
        chk("rst_fill_valid", 128'(fill_valid), 128'(1'b0));
        chk("rst_fill_line", fill_line, 128'd0);
        chk("rst_fill_meta",
            128'({fill_tag, fill_set, fill_way}), 128'(9'd0));
        rst       = 1'b0;
        miss_req  = 1'b0;
        hit_valid = 1'b0;

        // Basic refill with address sequence checking.
        refill(12'hFF0, 1'b1, 0, 3'd0, 1'b0);
        chk("ff0_line", fill_line, exp_line(12'hFF0));
        chk("ff0_tag", 128'(fill_tag), 128'(5'h1F));
        chk("ff0_set", 128'(fill_set), 128'(3'h7));
        chk("ff0_way", 128'(fill_way), 128'(1'b1));
        chk("ff0_idle_busy", 128'(busy), 128'(1'b0));
        chk("ff0_idle_fv", 128'(fill_valid), 128'(1'b0));
        chk("ff0_idle_addr", 128'(mem_addr), 128'(12'h000));

        // Victim selection from the LRU bits.
        refill(12'h01F, 1'b0, 0, 3'd0, 1'b0);
        chk("01f_set", 128'(fill_set), 128'(3'h1));
        chk("01f_tag", 128'(fill_tag), 128'(5'h00));
        chk("01f_way", 128'(fill_way), 128'(1'b1));
        chk("01f_line", fill_line, exp_line(12'h01F));
        refill(12'hF70, 1'b0, 0, 3'd0, 1'b0);
        chk("f70_way", 128'(fill_way), 128'(1'b0));
        chk("f70_tag", 128'(fill_tag), 128'(5'h1E));

        // Hit sets lru[3]=1; victim 0 latched; FETCH hit must not move it.
        hit_valid = 1'b1;
        hit_set   = 3'd3;
        hit_way   = 1'b1;
        step();
        hit_valid = 1'b0;
        refill(12'h030, 1'b0, 5, 3'd3, 1'b0);
        chk("s3_latched_way", 128'(fill_way), 128'(1'b0));
        // lru[3]=0 -> victim 1; DONE-cycle hit to way 0 loses to fill.
        refill(12'h030, 1'b0, 18, 3'd3, 1'b0);
        chk("s3_way1", 128'(fill_way), 128'(1'b1));
        refill(12'h030, 1'b0, 0, 3'd0, 1'b0);
        chk("s3_fill_wins", 128'(fill_way), 128'(1'b0));

        // miss_req held high: one pulse, re-accepted from first IDLE.
        miss_req  = 1'b1;
        miss_addr = 12'h100;
        step();
        cnt = 0;
        for (int i = 1; i <= 18; i++) begin
            if (fill_valid) cnt++;
            step();
        end
        chk("held_pulses", 128'(cnt), 128'(1));
        chk("held_idle", 128'(busy), 128'(1'b0));
        step();
        miss_req = 1'b0;
        chk("held_reaccept", 128'(busy), 128'(1'b1));
        chk("held_addr0", 128'(mem_addr), 128'(12'h100));

        // Reset at beat 7 of the re-accepted refill.
        for (int i = 0; i < 7; i++) step();
        chk("beat7_addr", 128'(mem_addr), 128'(12'h107));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", 128'(busy), 128'(1'b0));
        chk("mid_rst_rd", 128'(mem_rd), 128'(1'b0));
        chk("mid_rst_fill_line", fill_line, 128'd0);
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (fill_valid || busy) cnt++;
            step();
        end
        chk("mid_rst_no_fill", 128'(cnt), 128'(0));
        refill(12'h200, 1'b1, 0, 3'd0, 1'b0);
        chk("post_rst_line", fill_line, exp_line(12'h200));
        chk("post_rst_way", 128'(fill_way), 128'(1'b1));
        chk("post_rst_tag", 128'(fill_tag), 128'(5'h04));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
